// File: rtl/usr_shift_seq.sv
// usr_shift_seq: universal shift register with a start/busy/done sequenced multi-bit shift engine.
// Optional arithmetic SHR via `define USR_ARITH_SHIFT_EN (adds the arith input).
module usr_shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
`ifdef USR_ARITH_SHIFT_EN
  input  logic             arith,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [1:0] OP_LOAD = 2'd0, OP_SHR = 2'd1, OP_SHL = 2'd2;
  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] q_n, shifted;
  logic [AMT_W-1:0] cnt, cnt_n, sat;
  logic [1:0] op_r, op_n;
  logic sout_n, shr_fill;
`ifdef USR_ARITH_SHIFT_EN
  logic arith_r, arith_n;
  assign shr_fill = arith_r ? q[WIDTH-1] : sin;
`else
  assign shr_fill = sin;
`endif
  assign sat = amount > AMT_MAX ? AMT_MAX : amount;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  // ROR shares the right-shift path with q[0] recirculated into the MSB
  assign shifted = op_r == OP_SHL ? {q[WIDTH-2:0], sin} :
                   op_r == OP_SHR ? {shr_fill, q[WIDTH-1:1]} : {q[0], q[WIDTH-1:1]};
  always_comb begin
    state_n = state;
    q_n = q;
    sout_n = sout;
    cnt_n = cnt;
    op_n = op_r;
`ifdef USR_ARITH_SHIFT_EN
    arith_n = arith_r;
`endif
    case (state)
      IDLE: if (start) begin
        op_n = op;
`ifdef USR_ARITH_SHIFT_EN
        arith_n = arith;
`endif
        q_n = op == OP_LOAD ? d : q;
        cnt_n = op == OP_LOAD ? '0 : sat;
        state_n = (op == OP_LOAD || sat == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        q_n = shifted;
        sout_n = op_r == OP_SHL ? q[WIDTH-1] : q[0];
        cnt_n = cnt - AMT_W'(1);
        state_n = cnt == AMT_W'(1) ? DONE : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q <= '0;
      sout <= 1'b0;
      cnt <= '0;
      op_r <= OP_LOAD;
`ifdef USR_ARITH_SHIFT_EN
      arith_r <= 1'b0;
`endif
    end else begin
      state <= state_n;
      q <= q_n;
      sout <= sout_n;
      cnt <= cnt_n;
      op_r <= op_n;
`ifdef USR_ARITH_SHIFT_EN
      arith_r <= arith_n;
`endif
    end
  end
endmodule

// File: doc/usr_shift_seq.md
Name: usr_shift_seq

Overview:
Parametrised universal shift register with a sequenced multi-bit shift engine. It is the next generation of the 8-bit mode-selected `sr` block. It adds generic width, a start/busy/done handshake, a shift amount of N bits applied one bit per clock, a serial in/out path and rotation. It sits beside datapath registers that need controlled serialisation or alignment.

Parameters:
- WIDTH, 8, data register width in bits (>=2).
- AMT_W, $clog2(WIDTH+1), width of the shift-amount port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- op  in  2  operation: 00 LOAD, 01 SHR, 10 SHL, 11 ROR.
- amount  in  AMT_W  number of single-bit shifts; values >WIDTH saturate to WIDTH.
- d  in  WIDTH  parallel load data.
- sin  in  1  serial input; enters MSB on SHR, LSB on SHL, ignored on ROR/LOAD.
- q  out  WIDTH  register contents.
- sout  out  1  registered copy of the last bit shifted out (bit 0 for SHR/ROR, bit WIDTH-1 for SHL).
- busy  out  1  high while in SHIFT state.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, sync-released by system): q=0, sout=0, busy=0, done=0, state=IDLE, counter=0.
- Reset mid-operation aborts immediately. Same values as above. No done pulse.
- Registered Moore outputs: busy=(state==SHIFT), done=(state==DONE).
- IDLE: q holds. On edge with start=1, op and saturated amount are latched.
  - LOAD: q<=d; state<=DONE. sout unchanged.
  - Shift op, amount=0: state<=DONE; q and sout unchanged.
  - Shift op, amount>0: counter<=amount; state<=SHIFT.
- SHIFT: each edge performs exactly one single-bit shift using the latched op and decrements counter.
  - sin is sampled at each shift edge.
  - On the edge where counter goes 1->0: state<=DONE.
  - N-bit shift: busy high N cycles, then done high 1 cycle.
- DONE: lasts exactly one cycle, then state<=IDLE unconditionally.
- start is ignored while busy or in DONE; no queuing. d, op, amount may change freely after the start edge.
- SHR: q<={sin,q[W-1:1]}, sout<=q[0].
- SHL: q<={q[W-2:0],sin}, sout<=q[W-1].
- ROR: q<={q[0],q[W-1:1]}, sout<=q[0].
- ROR by WIDTH returns the original q.
- No wrap-around of amount beyond saturation; counter never underflows.

Optional Feature:
- Macro USR_ARITH_SHIFT_EN.
  - Defined: adds input port arith (1 bit), latched with op on start. When arith=1 and op=SHR, MSB is replicated instead of taking sin; sout behaviour unchanged. arith is ignored for other ops.
  - Undefined: port absent; SHR is always logical (sin into MSB).

Test Plan (WIDTH=8):
1. After reset, start op=LOAD d=63 -> next edge q=0x3F, busy never high, done high exactly 1 cycle, sout=0.
2. q=0x3F, start op=SHR amount=2 sin=0 -> busy 2 cycles, q=0x0F, sout=1, then done 1 cycle.
3. q=0x81, start op=SHL amount=3 sin=1 -> q sequence 0x03,0x07,0x0F; final sout=0; done 1 cycle after last shift.
4. q=0xA5, start op=ROR amount=8 -> busy 8 cycles, q=0xA5. Amount=15 saturates to 8 with the same result. A start pulsed mid-shift is ignored (q still 0xA5, single done).
5. Start op=SHR amount=0 -> q unchanged, busy never high, done 1 cycle after start. Then assert rst_n=0 during a 6-bit SHR -> q=0, busy=0, done=0 immediately, no done pulse after release.
6. USR_ARITH_SHIFT_EN defined: q=0x80, start op=SHR arith=1 amount=3 sin=0 -> q=0xF0. Same with arith=0 -> q=0x10.
